sync_fifo_fwft: RTL and testbench
=================================

Name: sync_fifo_fwft

Overview:
Parametrised single-clock FIFO, next generation of the team's basic FIFO.
- Adds a selectable read mode (registered or first-word-fall-through).
- Adds an occupancy level output and programmable almost-full/almost-empty flags.
- Adds sticky overflow/underflow error flags.
- Sits between producer and consumer blocks in the same clock domain, as a rate-decoupling buffer.

Parameters:
DATA_WIDTH, 32, width of each stored word
FIFO_DEPTH, 16, number of entries; power of two, >= 2
AFULL_THRESHOLD, 12, afull_o asserted when level >= this; legal range 1..FIFO_DEPTH
AEMPTY_THRESHOLD, 2, aempty_o asserted when level <= this; legal range 0..FIFO_DEPTH-1
FWFT_MODE, 0, 0 = registered read (1-cycle latency); 1 = first-word-fall-through

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  reset, asynchronous, active-low
wren_i  input  1  write request
wdata_i  input  DATA_WIDTH  write data
rden_i  input  1  read request / pop
rdata_o  output  DATA_WIDTH  read data
full_o  output  1  level == FIFO_DEPTH
empty_o  output  1  level == 0
afull_o  output  1  almost full
aempty_o  output  1  almost empty
level_o  output  $clog2(FIFO_DEPTH)+1  current occupancy
overflow_o  output  1  sticky: write attempted while full
underflow_o  output  1  sticky: read attempted while empty
clr_err_i  input  1  clears overflow_o/underflow_o

Behaviour:
- Reset (rst_n low, asynchronous) forces:
  - read/write pointers = 0, level_o = 0
  - empty_o = 1, full_o = 0, aempty_o = 1, afull_o = 0
  - overflow_o = 0, underflow_o = 0, rdata_o = 0
  - Memory array is not reset.
- Reset mid-operation discards all contents; a read after reset release sees empty_o = 1.
- Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally. full/empty derive from level or the pointer MSB compare; both methods must agree.
- Accepted write: wren_i && !full_o. Stores wdata_i at the write pointer, increments the write pointer.
- Accepted read: rden_i && !empty_o. Increments the read pointer.
- Level update per edge: +1 on write only, -1 on read only, unchanged on both or neither.
- Simultaneous wren_i and rden_i:
  - Not full and not empty: both accepted.
  - When full: read accepted, write rejected, overflow set.
  - When empty: write accepted, read rejected, underflow set.
  - No bypass of the written word on the empty case.
- Flags are registered-level derived, valid in the same cycle level_o changes:
  - afull_o = (level_o >= AFULL_THRESHOLD)
  - aempty_o = (level_o <= AEMPTY_THRESHOLD)
- FWFT_MODE = 0:
  - rdata_o is a register, loaded with the head word on the edge that accepts a read.
  - Data is valid the cycle after the rden_i edge.
  - rdata_o holds its value otherwise, including on rejected reads.
- FWFT_MODE = 1:
  - rdata_o continuously shows the head entry; it is valid whenever empty_o = 0.
  - rden_i acknowledges/pops the head; the next word appears the cycle after the pop.
  - rdata_o is don't-care while empty.
- overflow_o is set on wren_i && full_o && !(accepted read in same cycle making room).
  - This design does not allow write-through-when-full, so overflow is set whenever wren_i && full_o.
- underflow_o is set on rden_i && empty_o.
- Error flags stay set until clr_err_i is high at an edge. If set and clear coincide, set wins.
- Rejected operations never change pointers, level or memory.

Optional Feature:
FIFO_SOFT_FLUSH_EN
- Defined:
  - Adds input flush_i (1 bit).
  - flush_i high at an edge zeroes both pointers and level_o; wren_i/rden_i in that cycle are ignored.
  - In mode 0, rdata_o is held, not cleared.
  - Error flags are unaffected.
- Undefined: no flush_i port; contents are cleared only by rst_n.

Test Plan:
- Defaults; reset, then write 0..15 on 16 consecutive cycles -> level_o steps 1..16; afull_o rises at level 12; full_o = 1 after 16th write; empty_o = 0 after first write.
- From full, 17th write of 0xDEAD -> write rejected, overflow_o = 1, level_o stays 16. Pulse clr_err_i -> overflow_o = 0.
- FWFT_MODE = 0: read 16 times -> rdata_o = 0..15, each one cycle after its rden_i edge. aempty_o rises at level 2. Extra read while empty -> underflow_o = 1, rdata_o holds 15.
- FWFT_MODE = 1: write 0xA5 into empty FIFO -> rdata_o = 0xA5 the cycle after the write while empty_o = 0. Pop -> empty_o = 1.
- Level 8: wren_i and rden_i together for 20 cycles with incrementing data -> level_o stays 8, pointers wrap, read order preserved. Simultaneous write+read at level 0 -> underflow_o = 1, level_o = 1.
- Mid-stream assert rst_n low asynchronously at level 5 -> all outputs at reset values immediately. With FIFO_SOFT_FLUSH_EN: flush_i at level 9 -> level_o = 0, empty_o = 1 next cycle, overflow_o unchanged.

Source files
------------

// File: rtl/sync_fifo_fwft.sv
// ---------------------------------------------------------------------------
// sync_fifo_fwft
//
// Parametrised single-clock FIFO used as a rate-decoupling buffer between a
// producer and a consumer in the same clock domain. The read side is either
// registered (one cycle of latency after an accepted pop) or
// first-word-fall-through (head entry always visible on rdata_o).
// Provides an occupancy count, programmable almost-full/almost-empty flags
// and sticky overflow/underflow error flags.
//
// Optional feature macro: FIFO_SOFT_FLUSH_EN
//   When defined, adds flush_i. A flush empties the FIFO synchronously
//   without touching the error flags or the registered read data.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst_n        asynchronous active-low reset
//   wren_i       write request
//   wdata_i      write data
//   rden_i       read request / pop
//   flush_i      synchronous flush (only with FIFO_SOFT_FLUSH_EN)
//   clr_err_i    clears overflow_o / underflow_o
//   rdata_o      read data
//   full_o       level_o == FIFO_DEPTH
//   empty_o      level_o == 0
//   afull_o      level_o >= AFULL_THRESHOLD
//   aempty_o     level_o <= AEMPTY_THRESHOLD
//   level_o      current occupancy
//   overflow_o   sticky: write attempted while full
//   underflow_o  sticky: read attempted while empty
// ---------------------------------------------------------------------------
module sync_fifo_fwft #(
    parameter int DATA_WIDTH       = 32,
    parameter int FIFO_DEPTH       = 16,
    parameter int AFULL_THRESHOLD  = 12,
    parameter int AEMPTY_THRESHOLD = 2,
    parameter int FWFT_MODE        = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wren_i,
    input  logic [DATA_WIDTH-1:0]         wdata_i,
    input  logic                          rden_i,
`ifdef FIFO_SOFT_FLUSH_EN
    input  logic                          flush_i,
`endif
    input  logic                          clr_err_i,
    output logic [DATA_WIDTH-1:0]         rdata_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic                          afull_o,
    output logic                          aempty_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
    output logic                          overflow_o,
    output logic                          underflow_o
);

    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = ADDR_W + 1;

    localparam logic [LVL_W-1:0] DEPTH_LVL  = LVL_W'(FIFO_DEPTH);
    localparam logic [LVL_W-1:0] AFULL_LVL  = LVL_W'(AFULL_THRESHOLD);
    localparam logic [LVL_W-1:0] AEMPTY_LVL = LVL_W'(AEMPTY_THRESHOLD);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

    // Pointers carry one extra wrap bit so they can run freely modulo 2*DEPTH.
    logic [ADDR_W:0]    wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]    rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q,  level_d;
    logic               overflow_q,  overflow_d;
    logic               underflow_q, underflow_d;

    logic               full;
    logic               empty;
    logic               flush;
    logic               wr_accept;
    logic               rd_accept;

`ifdef FIFO_SOFT_FLUSH_EN
    assign flush = flush_i;
`else
    assign flush = 1'b0;
`endif

    assign full  = (level_q == DEPTH_LVL);
    assign empty = (level_q == '0);

    // A flush cycle ignores both requests, so neither side is accepted.
    assign wr_accept = wren_i && !full  && !flush;
    assign rd_accept = rden_i && !empty && !flush;

    // Next-state for pointers, level and sticky error flags.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (wr_accept) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (rd_accept) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({wr_accept, rd_accept})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end

        // Set has priority over clear when both happen on the same edge.
        overflow_d  = (wren_i && full  && !flush) || (overflow_q  && !clr_err_i);
        underflow_d = (rden_i && empty && !flush) || (underflow_q && !clr_err_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= wdata_i;
        end
    end

    generate
        if (FWFT_MODE != 0) begin : g_fwft
            // Head entry is shown directly; forced to zero while empty so the
            // output is clean out of reset.
            assign rdata_o = empty ? '0 : mem_q[rd_ptr_q[ADDR_W-1:0]];
        end else begin : g_reg
            logic [DATA_WIDTH-1:0] rdata_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rdata_q <= '0;
                end else if (rd_accept) begin
                    rdata_q <= mem_q[rd_ptr_q[ADDR_W-1:0]];
                end
            end

            assign rdata_o = rdata_q;
        end
    endgenerate

    assign full_o      = full;
    assign empty_o     = empty;
    assign afull_o     = (level_q >= AFULL_LVL);
    assign aempty_o    = (level_q <= AEMPTY_LVL);
    assign level_o     = level_q;
    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo_fwft
//
// Drives a registered-read instance and a first-word-fall-through instance of
// sync_fifo_fwft with identical stimulus and compares both against a
// queue-based reference model. Flush stimulus is exercised only when
// FIFO_SOFT_FLUSH_EN is defined.
// ---------------------------------------------------------------------------
module tb_sync_fifo_fwft;

   localparam int DW     = 32;
   localparam int DEPTH  = 16;
   localparam int AFULL  = 12;
   localparam int AEMPTY = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          wrenIn = 1'b0;
   logic [DW-1:0] wdataIn = '0;
   logic          rdenIn = 1'b0;
   logic          clrIn = 1'b0;
   logic          flushIn = 1'b0;

   logic [DW-1:0] rdata0, rdata1;
   logic          full0, empty0, afull0, aempty0, ovf0, unf0;
   logic          full1, empty1, afull1, aempty1, ovf1, unf1;
   logic [4:0]    level0, level1;

   int compared = 0;
   int mismatched = 0;

   // Reference model state: contents as a queue plus sticky flags.
   logic [DW-1:0] mq[$];
   bit            mOvf = 0;
   bit            mUnf = 0;
   logic [DW-1:0] mRdata0 = '0;

   typedef struct {
      bit            wr;
      logic [DW-1:0] data;
      bit            rd;
      bit            clr;
      int            expLevel;
      bit            expFull;
      bit            expEmpty;
      bit            expAfull;
      bit            expAempty;
      bit            expOvf;
      bit            expUnf;
      logic [DW-1:0] expRdata0;
   } vec_t;

   vec_t vecs[35];

   always #5 clk = ~clk;

   sync_fifo_fwft #(.FWFT_MODE(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .wren_i(wrenIn), .wdata_i(wdataIn), .rden_i(rdenIn),
`ifdef FIFO_SOFT_FLUSH_EN
      .flush_i(flushIn),
`endif
      .clr_err_i(clrIn), .rdata_o(rdata0), .full_o(full0), .empty_o(empty0),
      .afull_o(afull0), .aempty_o(aempty0), .level_o(level0),
      .overflow_o(ovf0), .underflow_o(unf0)
   );

   sync_fifo_fwft #(.FWFT_MODE(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .wren_i(wrenIn), .wdata_i(wdataIn), .rden_i(rdenIn),
`ifdef FIFO_SOFT_FLUSH_EN
      .flush_i(flushIn),
`endif
      .clr_err_i(clrIn), .rdata_o(rdata1), .full_o(full1), .empty_o(empty1),
      .afull_o(afull1), .aempty_o(aempty1), .level_o(level1),
      .overflow_o(ovf1), .underflow_o(unf1)
   );

   // Single comparison point: counts, and reports any disagreement.
   task automatic cmp(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference behaviour for one rising edge, using pre-edge model state.
   task automatic modelStep();
      bit isFull, isEmpty;
      isFull  = (mq.size() == DEPTH);
      isEmpty = (mq.size() == 0);
      if (flushIn) begin
         mq.delete();
      end else begin
         if (rdenIn && !isEmpty) mRdata0 = mq.pop_front();
         if (wrenIn && !isFull) mq.push_back(wdataIn);
      end
      mOvf = (wrenIn && isFull && !flushIn) || (mOvf && !clrIn);
      mUnf = (rdenIn && isEmpty && !flushIn) || (mUnf && !clrIn);
   endtask

   task automatic modelReset();
      mq.delete();
      mOvf = 0;
      mUnf = 0;
      mRdata0 = '0;
   endtask

   // Drive one cycle of requests from a falling edge, update the model on the
   // rising edge and return on the next falling edge for sampling.
   task automatic applyStimulus(input bit wr, input logic [DW-1:0] d, input bit rd,
                                input bit clr, input bit fl);
      wrenIn = wr;
      wdataIn = d;
      rdenIn = rd;
      clrIn = clr;
      flushIn = fl;
      @(posedge clk);
      modelStep();
      @(negedge clk);
      wrenIn = 0;
      rdenIn = 0;
      clrIn = 0;
      flushIn = 0;
   endtask

   task automatic checkOutput();
      int lvl;
      lvl = mq.size();
      cmp("level0", 32'(level0), 32'(lvl));
      cmp("full0", 32'(full0), 32'(lvl == DEPTH));
      cmp("empty0", 32'(empty0), 32'(lvl == 0));
      cmp("afull0", 32'(afull0), 32'(lvl >= AFULL));
      cmp("aempty0", 32'(aempty0), 32'(lvl <= AEMPTY));
      cmp("overflow0", 32'(ovf0), 32'(mOvf));
      cmp("underflow0", 32'(unf0), 32'(mUnf));
      cmp("rdata0", rdata0, mRdata0);
      cmp("level1", 32'(level1), 32'(lvl));
      cmp("overflow1", 32'(ovf1), 32'(mOvf));
      if (lvl > 0) cmp("rdata1_head", rdata1, mq[0]);
   endtask

   task automatic checkResetState(input string tag);
      cmp({tag, "_level0"}, 32'(level0), 32'd0);
      cmp({tag, "_empty0"}, 32'(empty0), 32'd1);
      cmp({tag, "_full0"}, 32'(full0), 32'd0);
      cmp({tag, "_aempty0"}, 32'(aempty0), 32'd1);
      cmp({tag, "_afull0"}, 32'(afull0), 32'd0);
      cmp({tag, "_ovf0"}, 32'(ovf0), 32'd0);
      cmp({tag, "_unf0"}, 32'(unf0), 32'd0);
      cmp({tag, "_rdata0"}, rdata0, 32'd0);
      cmp({tag, "_rdata1"}, rdata1, 32'd0);
      cmp({tag, "_level1"}, 32'(level1), 32'd0);
   endtask

   initial begin
      int pWr, pRd;

      // Directed vectors: fill, overflow, clear, drain, underflow.
      for (int i = 0; i < 16; i++) begin
         vecs[i] = '{1, 32'(i), 0, 0, i + 1, (i == 15), 0, (i + 1 >= AFULL),
                     (i + 1 <= AEMPTY), 0, 0, 32'd0};
      end
      vecs[16] = '{1, 32'hDEAD, 0, 0, 16, 1, 0, 1, 0, 1, 0, 32'd0};
      vecs[17] = '{0, 32'd0, 0, 1, 16, 1, 0, 1, 0, 0, 0, 32'd0};
      for (int k = 0; k < 16; k++) begin
         vecs[18 + k] = '{0, 32'd0, 1, 0, 15 - k, 0, (k == 15), (15 - k >= AFULL),
                          (15 - k <= AEMPTY), 0, 0, 32'(k)};
      end
      vecs[34] = '{0, 32'd0, 1, 0, 0, 0, 1, 0, 1, 0, 1, 32'd15};

      // Reset state while held in reset.
      @(negedge clk);
      @(negedge clk);
      checkResetState("reset");
      rst_n = 1'b1;
      modelReset();

      for (int v = 0; v < 35; v++) begin
         applyStimulus(vecs[v].wr, vecs[v].data, vecs[v].rd, vecs[v].clr, 0);
         cmp($sformatf("vec%0d_level", v), 32'(level0), 32'(vecs[v].expLevel));
         cmp($sformatf("vec%0d_full", v), 32'(full0), 32'(vecs[v].expFull));
         cmp($sformatf("vec%0d_empty", v), 32'(empty0), 32'(vecs[v].expEmpty));
         cmp($sformatf("vec%0d_afull", v), 32'(afull0), 32'(vecs[v].expAfull));
         cmp($sformatf("vec%0d_aempty", v), 32'(aempty0), 32'(vecs[v].expAempty));
         cmp($sformatf("vec%0d_ovf", v), 32'(ovf0), 32'(vecs[v].expOvf));
         cmp($sformatf("vec%0d_unf", v), 32'(unf0), 32'(vecs[v].expUnf));
         cmp($sformatf("vec%0d_rdata0", v), rdata0, vecs[v].expRdata0);
         checkOutput();
      end

      // Fall-through: written word visible the cycle after the write.
      applyStimulus(0, 0, 0, 1, 0);
      applyStimulus(1, 32'hA5, 0, 0, 0);
      cmp("fwft_rdata1", rdata1, 32'hA5);
      cmp("fwft_empty1", 32'(empty1), 32'd0);
      checkOutput();
      applyStimulus(0, 0, 1, 0, 0);
      cmp("fwft_pop_empty1", 32'(empty1), 32'd1);
      checkOutput();

      // Steady-state simultaneous read/write at level 8 with pointer wrap.
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1, 32'(100 + i), 0, 0, 0);
         checkOutput();
      end
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1, 32'(200 + i), 1, 0, 0);
         checkOutput();
      end
      cmp("simul_level8", 32'(level0), 32'd8);
      for (int i = 0; i < 8; i++) begin
         applyStimulus(0, 0, 1, 0, 0);
         checkOutput();
      end
      cmp("drain_last_rdata0", rdata0, 32'd219);

      // Simultaneous read/write while empty: write only, underflow set.
      applyStimulus(1, 32'h77, 1, 0, 0);
      cmp("empty_rw_unf", 32'(unf0), 32'd1);
      cmp("empty_rw_level", 32'(level0), 32'd1);
      cmp("empty_rw_rdata1", rdata1, 32'h77);
      checkOutput();

      // Randomised traffic in phases biased toward full, empty and balanced.
      for (int ph = 0; ph < 3; ph++) begin
         pWr = (ph == 0) ? 75 : (ph == 1) ? 25 : 50;
         pRd = (ph == 0) ? 25 : (ph == 1) ? 75 : 50;
         for (int c = 0; c < 150; c++) begin
            bit fl;
`ifdef FIFO_SOFT_FLUSH_EN
            fl = ($urandom_range(0, 99) < 2);
`else
            fl = 0;
`endif
            applyStimulus($urandom_range(0, 99) < pWr, $urandom, $urandom_range(0, 99) < pRd,
                          $urandom_range(0, 99) < 5, fl);
            checkOutput();
         end
      end

      // Asynchronous reset mid-stream at level 5.
      applyStimulus(0, 0, 0, 1, 0);
      while (mq.size() > 5) begin
         applyStimulus(0, 0, 1, 0, 0);
      end
      while (mq.size() < 5) begin
         applyStimulus(1, $urandom, 0, 0, 0);
      end
      applyStimulus(0, 0, 1, 0, 0);
      applyStimulus(1, $urandom, 0, 0, 0);
      checkOutput();
      #2;
      rst_n = 1'b0;
      #1;
      modelReset();
      checkResetState("async");
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(0, 0, 1, 0, 0);
      cmp("post_reset_empty", 32'(empty0), 32'd1);
      cmp("post_reset_unf", 32'(unf0), 32'd1);
      checkOutput();

`ifdef FIFO_SOFT_FLUSH_EN
      // Flush at level 9 with both requests active: empties, keeps flags.
      for (int i = 0; i < 9; i++) begin
         applyStimulus(1, 32'(300 + i), 0, 0, 0);
      end
      applyStimulus(0, 0, 1, 0, 0);
      applyStimulus(1, 32'd309, 0, 0, 0);
      checkOutput();
      applyStimulus(1, 32'hBEEF, 1, 0, 1);
      cmp("flush_level", 32'(level0), 32'd0);
      cmp("flush_empty", 32'(empty0), 32'd1);
      cmp("flush_unf_kept", 32'(unf0), 32'd1);
      cmp("flush_rdata0_held", rdata0, 32'd300);
      checkOutput();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
